// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two requesters
// Define ALU_ARB_OPCHK_EN to add rsp_err and suppress out-of-range opcodes (sel > 4'b1010).
module alu_share_arbiter #(
    parameter int ALU_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [ALU_WIDTH-1:0] req0_data1,
    input  logic [ALU_WIDTH-1:0] req0_data2,
    input  logic [3:0]           req0_sel,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [ALU_WIDTH-1:0] req1_data1,
    input  logic [ALU_WIDTH-1:0] req1_data2,
    input  logic [3:0]           req1_sel,
    output logic [ALU_WIDTH-1:0] alu_data1,
    output logic [ALU_WIDTH-1:0] alu_data2,
    output logic [3:0]           alu_sel,
    input  logic [ALU_WIDTH-1:0] alu_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [ALU_WIDTH-1:0] rsp_data,
`ifdef ALU_ARB_OPCHK_EN
    output logic                 rsp_err,
`endif
    output logic                 busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic       last_grant;
    logic       grant0;
    logic       grant1;
    logic       bad_op;

    // On a tie the requester that did not win last time gets the ALU.
    always_comb begin
        grant0     = req0_valid & (~req1_valid | last_grant);
        grant1     = req1_valid & (~req0_valid | ~last_grant);
        req0_ready = rst_n & (state == IDLE) & grant0;
        req1_ready = rst_n & (state == IDLE) & grant1;
        busy       = state != IDLE;
    end

`ifdef ALU_ARB_OPCHK_EN
    assign bad_op = alu_sel > 4'd10;
`else
    assign bad_op = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            alu_data1  <= '0;
            alu_data2  <= '0;
            alu_sel    <= 4'b0000;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
`ifdef ALU_ARB_OPCHK_EN
            rsp_err    <= 1'b0;
`endif
        end else if (state == IDLE) begin
            if (grant0 | grant1) begin
                alu_data1  <= grant1 ? req1_data1 : req0_data1;
                alu_data2  <= grant1 ? req1_data2 : req0_data2;
                alu_sel    <= grant1 ? req1_sel : req0_sel;
                rsp_id     <= grant1;
                last_grant <= grant1;
                state      <= EXEC;
            end
        end else if (state == EXEC) begin
            rsp_data  <= bad_op ? '0 : alu_result;
            rsp_valid <= 1'b1;
`ifdef ALU_ARB_OPCHK_EN
            rsp_err   <= bad_op;
`endif
            state     <= RESP;
        end else if (state == RESP) begin
            if (rsp_ready) begin
                rsp_valid <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
                rsp_err   <= 1'b0;
`endif
                state     <= IDLE;
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and randomized checks of alu_share_arbiter against a
// transaction-level model; an ALU stub drives alu_result from the registered operands.
module tb_alu_share_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_data1 = '0, req0_data2 = '0, req1_data1 = '0, req1_data2 = '0;
    logic [3:0]  req0_sel = '0, req1_sel = '0;
    logic [31:0] alu_data1, alu_data2, alu_result, rsp_data;
    logic [3:0]  alu_sel;
    logic        rsp_valid, rsp_id, busy;
    logic        rsp_ready = 1'b1;
`ifdef ALU_ARB_OPCHK_EN
    logic        rsp_err;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit last = 1'b1;

    alu_share_arbiter #(.ALU_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data1(req0_data1),
        .req0_data2(req0_data2), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data1(req1_data1),
        .req1_data2(req1_data2), .req1_sel(req1_sel),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_sel(alu_sel),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
`ifdef ALU_ARB_OPCHK_EN
        .rsp_err(rsp_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << b[4:0];
            4'd3:    return {31'b0, $signed(a) < $signed(b)};
            4'd4:    return {31'b0, a < b};
            4'd5:    return a ^ b;
            4'd6:    return a >> b[4:0];
            4'd7:    return $signed(a) >>> b[4:0];
            4'd8:    return a | b;
            4'd9:    return a & b;
            4'd10:   return b;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    always_comb alu_result = alu_ref(alu_sel, alu_data1, alu_data2);

    function automatic logic [31:0] exp_data(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef ALU_ARB_OPCHK_EN
        return (op > 4'd10) ? 32'd0 : alu_ref(op, a, b);
`else
        return alu_ref(op, a, b);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete operation: offer, accept, EXEC, RESP held for 'hold' cycles, back to IDLE.
    task automatic txn(input string tag, input bit v0, input bit v1,
                       input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                       input int hold, output int acc);
        bit g;
        logic [3:0] op;
        logic [31:0] a, b, e;
        g  = (v0 && v1) ? !last : v1;
        op = g ? op1 : op0;
        a  = g ? a1 : a0;
        b  = g ? b1 : b0;
        e  = exp_data(op, a, b);
        req0_valid = v0; req0_sel = op0; req0_data1 = a0; req0_data2 = b0;
        req1_valid = v1; req1_sel = op1; req1_data1 = a1; req1_data2 = b1;
        rsp_ready = (hold == 0);
        #1 chk({tag, "_ready"}, {req1_ready, req0_ready}, g ? 32'd2 : 32'd1);
        @(negedge clk);
        acc = cyc;
        last = g;
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1 chk({tag, "_exec_busy_vld"}, {busy, rsp_valid}, 32'd2);
        chk({tag, "_alu_data1"}, alu_data1, a);
        chk({tag, "_alu_data2"}, alu_data2, b);
        chk({tag, "_alu_sel"}, alu_sel, op);
        @(negedge clk);
        #1 chk({tag, "_rsp_valid"}, rsp_valid, 1);
        chk({tag, "_rsp_data"}, rsp_data, e);
        chk({tag, "_rsp_id"}, rsp_id, g);
`ifdef ALU_ARB_OPCHK_EN
        chk({tag, "_rsp_err"}, rsp_err, op > 4'd10);
`endif
        for (int i = 0; i < hold; i++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            #1 chk({tag, "_hold_flags"}, {rsp_valid, busy, req1_ready, req0_ready}, 32'hC);
            @(negedge clk);
            #1 chk({tag, "_hold_data"}, rsp_data, e);
            chk({tag, "_hold_id"}, rsp_id, g);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        #1 chk({tag, "_idle"}, {rsp_valid, busy, req1_ready, req0_ready}, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last = 1'b1;
        #1;
    endtask

    initial begin
        int acc, prev;
        bit v0, v1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1 chk("rst_ready", {req1_ready, req0_ready}, 32'd0);
        chk("rst_flags", {rsp_valid, rsp_id, busy}, 32'd0);
        chk("rst_alu_data1", alu_data1, 32'd0);
        chk("rst_alu_data2", alu_data2, 32'd0);
        chk("rst_alu_sel", alu_sel, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        txn("t1_add", 1, 0, 4'd0, 32'd5, 32'd7, 4'd0, 32'd0, 32'd0, 0, acc);
        chk("t1_value", rsp_data, 32'd12);
        do_reset();
        txn("t2_tie_a", 1, 1, 4'd1, 32'd10, 32'd3, 4'd2, 32'd1, 32'd4, 0, acc);
        txn("t2_tie_b", 1, 1, 4'd1, 32'd10, 32'd3, 4'd2, 32'd1, 32'd4, 0, acc);
        chk("t2_value_b", rsp_data, 32'd16);
        txn("t2_tie_c", 1, 1, 4'd1, 32'd10, 32'd3, 4'd2, 32'd1, 32'd4, 0, acc);
        // a request withdrawn before any clock edge must leave no trace
        req0_valid = 1'b1; req0_sel = 4'd0;
        #1 chk("drop_ready", req0_ready, 1);
        #1 req0_valid = 1'b0;
        @(negedge clk);
        #1 chk("drop_idle", {busy, rsp_valid}, 32'd0);
        txn("drop_tie", 1, 1, 4'd8, 32'hF0, 32'h0F, 4'd9, 32'hFF, 32'h0F, 0, acc);
        txn("t3_hold", 1, 0, 4'd0, 32'd100, 32'd23, 4'd0, 32'd0, 32'd0, 5, acc);
        req1_valid = 1'b1; req1_sel = 4'd5; req1_data1 = 32'hA5A5A5A5; req1_data2 = 32'hFFFF0000;
        #1 chk("t4_ready", req1_ready, 1);
        @(negedge clk);
        req0_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk("t4_busy", {busy, rsp_valid, rsp_id}, 32'd0);
        chk("t4_ready_rst", {req1_ready, req0_ready}, 32'd0);
        chk("t4_alu_data1", alu_data1, 32'd0);
        chk("t4_alu_data2", alu_data2, 32'd0);
        chk("t4_alu_sel", alu_sel, 32'd0);
        chk("t4_rsp_data", rsp_data, 32'd0);
        last = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("t4_no_rsp", {rsp_valid, busy}, 32'd0);
        end
        txn("t4_tie", 1, 1, 4'd0, 32'd1, 32'd1, 4'd1, 32'd1, 32'd1, 0, acc);
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            txn("t5_sra", 0, 1, 4'd0, 32'd0, 32'd0, 4'd7, 32'h80000000, 32'd4, 0, acc);
            chk("t5_value", rsp_data, 32'hF8000000);
            if (i > 0) chk("t5_interval", acc - prev, 32'd3);
            prev = acc;
        end
        txn("t6_badop", 1, 0, 4'hF, 32'd9, 32'd9, 4'd0, 32'd0, 32'd0, 0, acc);
        for (int i = 0; i < 30; i++) begin
            {v1, v0} = 2'($urandom_range(1, 3));
            txn("rnd", v0, v1,
                4'($urandom_range(0, 15)), $urandom, $urandom,
                4'($urandom_range(0, 15)), $urandom, $urandom,
                int'($urandom_range(0, 3)), acc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
